// File: rtl/relobi_tmr_r_sync.sv
// Triple-modular-redundant synchroniser for the reliable-OBI R channel: collects one beat per
// replica, emits the bitwise majority, and forces a two-of-three vote if one replica stalls.
module relobi_tmr_r_sync #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 16,
    parameter int unsigned CntWidth      = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [2:0]                         r_valid_i,
    input  logic [2:0][DataWidth-1:0]          r_data_i,
    output logic [2:0]                         r_ready_o,
    output logic                               voted_valid_o,
    output logic [DataWidth-1:0]               voted_data_o,
    input  logic                               voted_ready_i,
    input  logic                               clear_i,
    output logic                               mismatch_o,
    output logic                               timeout_o,
    output logic [2:0]                         fault_o,
    output logic [2:0][CntWidth-1:0]           err_cnt_o
);

    // state   | meaning
    // COLLECT | filling empty slots from the replicas; timeout runs while exactly two are full
    // OUT     | voted beat presented downstream, waiting for voted_ready_i

    typedef enum logic {
        COLLECT = 1'b0,
        OUT     = 1'b1
    } state_e;

    localparam int unsigned          TmoW    = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0]      TmoLoad = TmoW'(TimeoutCycles);
    localparam logic [CntWidth-1:0]  CntMax  = '1;

    state_e                     state_q, state_d;
    logic [2:0]                 full_q, full_d;
    logic [2:0]                 drop_q, drop_d;
    logic [TmoW-1:0]            tmo_q, tmo_d;
    logic [2:0][DataWidth-1:0]  slot_q;
    logic [2:0][DataWidth-1:0]  vsrc;
    logic [DataWidth-1:0]       fill;
    logic [DataWidth-1:0]       vote;

    logic [2:0] hs;
    logic [2:0] capture;
    logic [2:0] discard;
    logic [2:0] missing;
    logic [2:0] diff;
    logic [2:0] err_inc;
    logic       two_full;
    logic       all_full;
    logic       tmo_fire;
    logic       go_out;

    assign r_ready_o = ({3{state_q == COLLECT}} & ~full_q) | drop_q;

    // A beat from a replica marked for dropping is swallowed instead of landing in its slot.
    assign hs      = r_valid_i & r_ready_o;
    assign capture = hs & ~drop_q;
    assign discard = hs & drop_q;
    assign missing = ~full_q;

    assign all_full = &full_q;
    assign two_full = (state_q == COLLECT) &&
                      ((full_q == 3'b011) || (full_q == 3'b101) || (full_q == 3'b110));

    // The late replica arriving in the expiring cycle wins over the forced vote.
    assign tmo_fire = two_full && (tmo_q == TmoW'(1)) && ((capture & missing) == 3'b000);
    assign go_out   = (state_q == COLLECT) && (all_full || tmo_fire);

    always_comb begin
        fill = slot_q[2];
        vsrc = slot_q;
        if (full_q[0]) begin
            fill = slot_q[0];
        end else if (full_q[1]) begin
            fill = slot_q[1];
        end
        for (int i = 0; i < 3; i++) begin
            vsrc[i] = full_q[i] ? slot_q[i] : fill;
        end
    end

    assign vote = (vsrc[0] & vsrc[1]) | (vsrc[0] & vsrc[2]) | (vsrc[1] & vsrc[2]);

    always_comb begin
        diff = '0;
        for (int i = 0; i < 3; i++) begin
            diff[i] = full_q[i] && (slot_q[i] != vote);
        end
    end

    assign err_inc = {3{go_out}} & (diff | ({3{tmo_fire}} & missing));

    always_comb begin
        state_d       = state_q;
        full_d        = full_q | capture;
        drop_d        = drop_q & ~discard;
        tmo_d         = TmoLoad;
        voted_valid_o = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (go_out) begin
                    state_d = OUT;
                end
                if (two_full && !tmo_fire) begin
                    tmo_d = tmo_q - TmoW'(1);
                end
                if (tmo_fire) begin
                    drop_d = drop_d | missing;
                end
            end
            OUT: begin
                voted_valid_o = 1'b1;
                if (voted_ready_i) begin
                    state_d = COLLECT;
                    full_d  = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            full_q  <= '0;
            drop_q  <= '0;
            tmo_q   <= TmoLoad;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (capture[i]) begin
                    slot_q[i] <= r_data_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            voted_data_o <= '0;
            mismatch_o   <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            mismatch_o <= go_out && (diff != 3'b000);
            timeout_o  <= tmo_fire;
            if (go_out) begin
                voted_data_o <= vote;
            end
        end
    end

    // Clear takes priority over any increment or fault set landing on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_o   <= '0;
            err_cnt_o <= '0;
        end else if (clear_i) begin
            fault_o   <= '0;
            err_cnt_o <= '0;
        end else begin
            fault_o <= fault_o | ({3{tmo_fire}} & missing);
            for (int i = 0; i < 3; i++) begin
                if (err_inc[i] && (err_cnt_o[i] != CntMax)) begin
                    err_cnt_o[i] <= err_cnt_o[i] + CntWidth'(1);
                end
            end
        end
    end

endmodule

// File: doc/relobi_tmr_r_sync.md
RELOBI_TMR_R_SYNC -- requirements
Module: relobi_tmr_r_sync

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of one flattened reliable-OBI R channel beat, ECC bits included.
REQ-002 SHALL have parameter TimeoutCycles, default 16: consecutive two-of-three cycles tolerated before forced vote.
REQ-003 SHALL have parameter CntWidth, default 8: width of each per-replica error counter.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port r_valid_i  input  3  per-replica R beat valid.
REQ-007 SHALL have port r_data_i  input  3xDataWidth  per-replica R beat.
REQ-008 SHALL have port r_ready_o  output  3  per-replica R beat ready.
REQ-009 SHALL have port voted_valid_o  output  1  voted beat valid.
REQ-010 SHALL have port voted_data_o  output  DataWidth  voted beat, bitwise majority.
REQ-011 SHALL have port voted_ready_i  input  1  downstream ready.
REQ-012 SHALL have port clear_i  input  1  clears counters and fault flags.
REQ-013 SHALL have port mismatch_o  output  1  one-cycle pulse, a present replica disagreed with the vote.
REQ-014 SHALL have port timeout_o  output  1  one-cycle pulse, forced vote on timeout.
REQ-015 SHALL have port fault_o  output  3  sticky per-replica late-beat flag.
REQ-016 SHALL have port err_cnt_o  output  3xCntWidth  per-replica saturating error count.

Function
REQ-017 SHALL hold one capture slot per replica; handshake on r_valid_i[i] and r_ready_o[i] in COLLECT fills slot i.
REQ-018 SHALL drive r_ready_o[i] = (state==COLLECT and slot i empty) or drop[i].
REQ-019 SHALL implement FSM states COLLECT (reset state) and OUT.
REQ-020 SHALL move COLLECT->OUT on the edge after all three slots are full, loading voted_data_o with the bitwise majority of the slots: 2-cycle latency from the last capture to voted_valid_o.
REQ-021 SHALL count consecutive COLLECT cycles with exactly two slots full.
REQ-022 SHALL move COLLECT->OUT when that count reaches TimeoutCycles.
- The empty slot is substituted with the lowest-index full slot for voting.
- timeout_o pulses; drop[i] and fault_o[i] are set for the missing replica i.
REQ-023 SHALL give the full vote precedence when the third beat is captured in the cycle the count would expire: no timeout.
REQ-024 SHALL clear the timeout count on entering OUT and whenever fewer than two slots are full.
REQ-025 SHALL assert voted_valid_o only in OUT, holding voted_data_o stable until voted_ready_i.
- On handshake: clear all slots, return to COLLECT.
REQ-026 SHALL, while drop[i] is set, accept and discard exactly one beat from replica i, then clear drop[i]; the slot is not filled.
REQ-027 SHALL, on entering OUT, pulse mismatch_o if any present slot differs from voted_data_o, incrementing err_cnt_o[i] for each such replica.
REQ-028 SHALL increment err_cnt_o[i] once on timeout for the missing replica i.
REQ-029 SHALL saturate each err_cnt_o[i] at 2^CntWidth-1.
REQ-030 SHALL, on clear_i, zero err_cnt_o and fault_o on the next edge; clear wins over a simultaneous increment or set; drop[] is unaffected.

Reset
REQ-031 SHALL, on rst_ni low, asynchronously enter COLLECT with all slots empty, drop[]=0 and counters zero.
- Outputs: r_ready_o=3'b111, voted_valid_o=0, voted_data_o=0, mismatch_o=0, timeout_o=0, fault_o=0, err_cnt_o=0.
REQ-032 SHALL discard any in-flight beat and pending vote on reset mid-operation; no beat is output after reset release.

Verification
REQ-033 SHALL cover: all replicas 0xA5A5A5A5 in the same cycle t -> voted_valid_o at t+2, data 0xA5A5A5A5, mismatch_o=0, counters 0.
REQ-034 SHALL cover: replica 1 sends 0xA5A5A5A4, others 0xA5A5A5A5 -> vote 0xA5A5A5A5, mismatch_o pulse, err_cnt_o[1]=1.
REQ-035 SHALL cover: replica 2 silent, replicas 0/1 send 0x1 and 0x3, TimeoutCycles=4 -> forced vote 0x1 after 4 two-full cycles.
- timeout_o pulse; fault_o=3'b100; err_cnt_o[1]=1, err_cnt_o[2]=1.
- Replica 2's next beat is dropped.
REQ-036 SHALL cover: voted_ready_i low 10 cycles -> voted_data_o stable, r_ready_o=0; ready high -> slots clear, COLLECT next cycle.
REQ-037 SHALL cover: CntWidth=2, replica 0 wrong in 5 beats -> err_cnt_o[0]=3; clear_i coincident with a 6th mismatch -> 0.
REQ-038 SHALL cover: rst_ni low while two slots full -> all REQ-031 values immediately; no voted beat after release.
